// File: rtl/cir_q_mp_if.sv
// Bundled issue / update / commit / status signals of the multi-port circular queue.
// Carries the optional flush strobe when CIR_Q_FLUSH_EN is defined.
interface cir_q_mp_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX   = 5,
  parameter int unsigned N_UPD = 2
);
  logic [1:0]             issue_cnt;
  logic [2*WIDTH-1:0]     issue_data;
  logic [2*IDX-1:0]       issue_idx;
  logic [N_UPD-1:0]       upd_valid;
  logic [N_UPD*IDX-1:0]   upd_idx;
  logic [N_UPD*WIDTH-1:0] upd_data;
  logic [1:0]             commit_cnt;
`ifdef CIR_Q_FLUSH_EN
  logic                   flush;
`endif
  logic [1:0]             head_rdy;
  logic [2*WIDTH-1:0]     head_data;
  logic [IDX-1:0]         head_idx;
  logic [IDX:0]           count;
  logic [IDX:0]           free_cnt;
  logic                   full;
  logic                   empty;
  logic                   err;

  modport slave (
    input  issue_cnt, issue_data, upd_valid, upd_idx, upd_data, commit_cnt,
`ifdef CIR_Q_FLUSH_EN
    input  flush,
`endif
    output issue_idx, head_rdy, head_data, head_idx, count, free_cnt, full, empty, err
  );

  modport master (
    output issue_cnt, issue_data, upd_valid, upd_idx, upd_data, commit_cnt,
`ifdef CIR_Q_FLUSH_EN
    output flush,
`endif
    input  issue_idx, head_rdy, head_data, head_idx, count, free_cnt, full, empty, err
  );
endinterface

// File: rtl/cir_q_mp.sv
// Multi-port circular queue: 2-wide issue at tail, N_UPD completion ports, 2-wide in-order retire.
// Optional synchronous flush port enabled by defining CIR_Q_FLUSH_EN.
module cir_q_mp #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX   = 5,
  parameter int unsigned N_UPD = 2
) (
  input logic         clk,
  input logic         rst,
  cir_q_mp_if.slave   io_q
);
  localparam int unsigned DEPTH = 1 << IDX;
  localparam int unsigned CW    = IDX + 1;

  logic [IDX-1:0]   r_head;
  logic [IDX-1:0]   r_tail;
  logic [IDX:0]     r_count;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_rdy;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic             r_err;

  logic [IDX-1:0]   w_head1;
  logic [IDX-1:0]   w_tail1;
  logic [IDX:0]     w_free;
  logic             w_rdy0;
  logic             w_rdy1;
  logic [1:0]       w_lead;
  logic             w_issue_ok;
  logic             w_commit_ok;
  logic [1:0]       w_issue_acc;
  logic [1:0]       w_commit_acc;
  logic [DEPTH-1:0] w_retire;
  logic [N_UPD-1:0] w_upd_hit;
  logic [DEPTH-1:0] w_valid_n;
  logic [DEPTH-1:0] w_rdy_n;

  assign w_head1 = r_head + IDX'(1);
  assign w_tail1 = r_tail + IDX'(1);
  assign w_free  = CW'(DEPTH) - r_count;

  // Head lanes only count as ready inside the occupied window.
  assign w_rdy0 = r_valid[r_head]  & r_rdy[r_head]  & (r_count >= CW'(1));
  assign w_rdy1 = r_valid[w_head1] & r_rdy[w_head1] & (r_count >= CW'(2));
  assign w_lead = w_rdy0 ? (w_rdy1 ? 2'd2 : 2'd1) : 2'd0;

  assign w_issue_ok   = (io_q.issue_cnt != 2'd3) && (CW'(io_q.issue_cnt) <= w_free);
  assign w_commit_ok  = io_q.commit_cnt <= w_lead;
  assign w_issue_acc  = w_issue_ok  ? io_q.issue_cnt  : 2'd0;
  assign w_commit_acc = w_commit_ok ? io_q.commit_cnt : 2'd0;

  always_comb begin
    w_retire = '0;
    if (w_commit_acc >= 2'd1) w_retire[r_head]  = 1'b1;
    if (w_commit_acc == 2'd2) w_retire[w_head1] = 1'b1;
  end

  // An update lands only on an entry that is live now and survives this cycle.
  always_comb begin
    w_upd_hit = '0;
    for (int p = 0; p < N_UPD; p++) begin
      w_upd_hit[p] = io_q.upd_valid[p]
                   & r_valid[io_q.upd_idx[p*IDX +: IDX]]
                   & ~w_retire[io_q.upd_idx[p*IDX +: IDX]];
    end
  end

  always_comb begin
    w_valid_n = r_valid & ~w_retire;
    w_rdy_n   = r_rdy   & ~w_retire;
    for (int p = 0; p < N_UPD; p++) begin
      if (w_upd_hit[p]) w_rdy_n[io_q.upd_idx[p*IDX +: IDX]] = 1'b1;
    end
    if (w_issue_acc >= 2'd1) begin
      w_valid_n[r_tail] = 1'b1;
      w_rdy_n[r_tail]   = 1'b0;
    end
    if (w_issue_acc == 2'd2) begin
      w_valid_n[w_tail1] = 1'b1;
      w_rdy_n[w_tail1]   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_rdy   <= '0;
      r_err   <= 1'b0;
    end
`ifdef CIR_Q_FLUSH_EN
    else if (io_q.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_rdy   <= '0;
      r_err   <= 1'b0;
    end
`endif
    else begin
      r_head  <= r_head + IDX'(w_commit_acc);
      r_tail  <= r_tail + IDX'(w_issue_acc);
      r_count <= r_count + CW'(w_issue_acc) - CW'(w_commit_acc);
      r_valid <= w_valid_n;
      r_rdy   <= w_rdy_n;
      r_err   <= ~w_issue_ok | ~w_commit_ok;
    end
  end

  // Data array is not reset; later ports and then issue writes take priority.
  always_ff @(posedge clk) begin
    for (int p = 0; p < N_UPD; p++) begin
      if (w_upd_hit[p]) r_data[io_q.upd_idx[p*IDX +: IDX]] <= io_q.upd_data[p*WIDTH +: WIDTH];
    end
    if (w_issue_acc >= 2'd1) r_data[r_tail]  <= io_q.issue_data[WIDTH-1:0];
    if (w_issue_acc == 2'd2) r_data[w_tail1] <= io_q.issue_data[2*WIDTH-1:WIDTH];
  end

  assign io_q.issue_idx = {w_tail1, r_tail};
  assign io_q.head_rdy  = {w_rdy1, w_rdy0};
  assign io_q.head_data = {r_data[w_head1], r_data[r_head]};
  assign io_q.head_idx  = r_head;
  assign io_q.count     = r_count;
  assign io_q.free_cnt  = w_free;
  assign io_q.full      = (r_count == CW'(DEPTH));
  assign io_q.empty     = (r_count == CW'(0));
  assign io_q.err       = r_err;
endmodule

// File: tb/tb_cir_q_mp.sv
// Self-checking bench for cir_q_mp: directed scenarios plus random traffic against a window-based queue model.
module tb_cir_q_mp;
  localparam int D = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cir_q_mp_if #(.WIDTH(32), .IDX(5), .N_UPD(2)) bus ();
  cir_q_mp #(.WIDTH(32), .IDX(5), .N_UPD(2)) dut (.clk(clk), .rst(rst), .io_q(bus));

  int n_chk = 0;
  int n_err = 0;

  // Reference model: occupied entries are the window head .. head+count-1.
  int          m_head, m_tail, m_count;
  bit          m_rdy  [D];
  logic [31:0] m_data [D];
  bit          m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit occupied(input int idx);
    return ((idx - m_head + D) % D) < m_count;
  endfunction

  function automatic bit retired(input int idx, input int cc);
    return ((idx - m_head + D) % D) < cc;
  endfunction

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_count = 0; m_err = 0;
    for (int i = 0; i < D; i++) m_rdy[i] = 0;
  endtask

  task automatic check_outputs();
    bit r0, r1;
    logic [4:0] t0, t1;
    r0 = (m_count >= 1) && m_rdy[m_head];
    r1 = (m_count >= 2) && m_rdy[(m_head + 1) % D];
    t0 = 5'(m_tail);
    t1 = 5'((m_tail + 1) % D);
    check("count",     64'(bus.count),    64'(m_count));
    check("free_cnt",  64'(bus.free_cnt), 64'(D - m_count));
    check("full",      64'(bus.full),     64'(m_count == D));
    check("empty",     64'(bus.empty),    64'(m_count == 0));
    check("head_idx",  64'(bus.head_idx), 64'(m_head));
    check("err",       64'(bus.err),      64'(m_err));
    check("issue_idx", 64'(bus.issue_idx), 64'({t1, t0}));
    check("head_rdy",  64'(bus.head_rdy), 64'({r1, r0}));
    if (r0) check("head_data0", 64'(bus.head_data[31:0]),  64'(m_data[m_head]));
    if (r1) check("head_data1", 64'(bus.head_data[63:32]), 64'(m_data[(m_head + 1) % D]));
  endtask

  task automatic model_step(input int ic, input logic [63:0] idat, input logic [1:0] uv,
                            input logic [9:0] uidx, input logic [63:0] udat, input int cc,
                            input bit fl);
    int lead;
    bit iok, cok;
    lead = 0;
    if (m_count >= 1 && m_rdy[m_head]) begin
      lead = 1;
      if (m_count >= 2 && m_rdy[(m_head + 1) % D]) lead = 2;
    end
    iok = (ic <= 2) && (ic <= D - m_count);
    cok = (cc <= lead);
    if (fl) begin
      model_reset();
      return;
    end
    m_err = !iok || !cok;
    for (int p = 0; p < 2; p++) begin
      int idx;
      idx = int'(uidx[p*5 +: 5]);
      if (uv[p] && occupied(idx) && !(cok && retired(idx, cc))) begin
        m_data[idx] = udat[p*32 +: 32];
        m_rdy[idx]  = 1;
      end
    end
    if (cok) begin
      for (int k = 0; k < cc; k++) m_rdy[(m_head + k) % D] = 0;
      m_head  = (m_head + cc) % D;
      m_count = m_count - cc;
    end
    if (iok) begin
      for (int k = 0; k < ic; k++) begin
        m_data[(m_tail + k) % D] = idat[k*32 +: 32];
        m_rdy[(m_tail + k) % D]  = 0;
      end
      m_tail  = (m_tail + ic) % D;
      m_count = m_count + ic;
    end
  endtask

  task automatic step(input int ic, input logic [63:0] idat, input logic [1:0] uv,
                      input logic [9:0] uidx, input logic [63:0] udat, input int cc,
                      input bit fl);
    bus.issue_cnt  = 2'(ic);
    bus.issue_data = idat;
    bus.upd_valid  = uv;
    bus.upd_idx    = uidx;
    bus.upd_data   = udat;
    bus.commit_cnt = 2'(cc);
`ifdef CIR_Q_FLUSH_EN
    bus.flush      = fl;
`endif
    check_outputs();
    model_step(ic, idat, uv, uidx, udat, cc, fl);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic idle();
    step(0, 64'h0, 2'b00, 10'h0, 64'h0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill();
    while (m_count < D) begin
      step((D - m_count) >= 2 ? 2 : 1, rnd64(), 2'b00, 10'h0, 64'h0, 0, 1'b0);
    end
  endtask

  initial begin
    bus.issue_cnt = '0; bus.issue_data = '0; bus.upd_valid = '0;
    bus.upd_idx = '0; bus.upd_data = '0; bus.commit_cnt = '0;
`ifdef CIR_Q_FLUSH_EN
    bus.flush = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("rst_head_rdy", 64'(bus.head_rdy), 64'd0);
    check("rst_free",     64'(bus.free_cnt), 64'(D));

    // Fill with issue_cnt=2, then an over-issue is rejected.
    for (int i = 0; i < D / 2; i++) step(2, rnd64(), 2'b00, 10'h0, 64'h0, 0, 1'b0);
    check("fill_full",  64'(bus.full),     64'd1);
    check("fill_free",  64'(bus.free_cnt), 64'd0);
    step(1, rnd64(), 2'b00, 10'h0, 64'h0, 0, 1'b0);
    check("overissue_err",   64'(bus.err),   64'd1);
    check("overissue_count", 64'(bus.count), 64'(D));

    // Ready indices 0/1, retire both.
    step(0, 64'h0, 2'b11, {5'd1, 5'd0}, {32'h1111_0001, 32'h0000_0000}, 0, 1'b0);
    step(0, 64'h0, 2'b00, 10'h0, 64'h0, 2, 1'b0);
    check("commit2_head",  64'(bus.head_idx), 64'd2);
    check("commit2_count", 64'(bus.count),    64'(D - 2));

    // Same-index update, highest port wins.
    step(0, 64'h0, 2'b11, {5'd2, 5'd2}, {32'h0000_5555, 32'h0000_AAAA}, 0, 1'b0);
    check("same_idx_data", 64'(bus.head_data[31:0]), 64'h5555);
    check("same_idx_rdy",  64'(bus.head_rdy),        64'b01);
    step(0, 64'h0, 2'b00, 10'h0, 64'h0, 1, 1'b0);

    // head_rdy=10: commit 1 rejected.
    step(0, 64'h0, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h0000_0444}, 0, 1'b0);
    check("rdy10", 64'(bus.head_rdy), 64'b10);
    step(0, 64'h0, 2'b00, 10'h0, 64'h0, 1, 1'b0);
    check("rdy10_err",  64'(bus.err),      64'd1);
    check("rdy10_head", 64'(bus.head_idx), 64'd3);

    // Full queue: simultaneous issue 1 and commit 1.
    fill();
    step(0, 64'h0, 2'b01, {5'd0, 5'd3}, {32'h0, 32'h0000_0333}, 0, 1'b0);
    step(1, rnd64(), 2'b00, 10'h0, 64'h0, 1, 1'b0);
    check("full_ic_cc_count", 64'(bus.count), 64'(D - 1));
    check("full_ic_cc_err",   64'(bus.err),   64'd1);

`ifdef CIR_Q_FLUSH_EN
    do_reset();
    for (int i = 0; i < 5; i++) step(2, rnd64(), 2'b00, 10'h0, 64'h0, 0, 1'b0);
    step(2, rnd64(), 2'b00, 10'h0, 64'h0, 0, 1'b1);
    check("flush_empty", 64'(bus.empty),    64'd1);
    check("flush_count", 64'(bus.count),    64'd0);
    check("flush_head",  64'(bus.head_idx), 64'd0);
    check("flush_err",   64'(bus.err),      64'd0);
`endif

    // Random traffic with wraparound and one mid-run reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int ic, cc, r;
      logic [9:0] uidx;
      logic [1:0] uv;
      bit fl;
      if (cyc == 1500) do_reset();
      r  = int'($urandom_range(0, 9));
      ic = (r == 9) ? 3 : r % 3;
      cc = int'($urandom_range(0, 2));
      uv = 2'($urandom());
      for (int p = 0; p < 2; p++) begin
        if (m_count > 0 && $urandom_range(0, 3) != 0)
          uidx[p*5 +: 5] = 5'((m_head + int'($urandom_range(0, m_count - 1))) % D);
        else
          uidx[p*5 +: 5] = 5'($urandom_range(0, D - 1));
      end
`ifdef CIR_Q_FLUSH_EN
      fl = ($urandom_range(0, 99) == 0);
`else
      fl = 1'b0;
`endif
      step(ic, rnd64(), uv, uidx, rnd64(), cc, fl);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cir_q_mp.md
# cir_q_mp

Multi-port circular queue for the out-of-order core's reorder buffer and similar in-order-retire structures. It allocates up to two entries per cycle at the tail, accepts N_UPD parallel completion broadcasts that write data and mark entries ready, and retires up to two contiguous ready entries per cycle from the head. Occupancy is count-based, so full and empty are exact and there is no pointer-equality ambiguity.

## Interface
- WIDTH, 32, data bits per entry
- IDX, 5, log2 of entry count; DEPTH = 2**IDX, IDX >= 2
- N_UPD, 2, number of update/broadcast ports
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- issue_cnt  in  2  entries to allocate this cycle (0, 1 or 2; 3 is illegal)
- issue_data  in  2*WIDTH  slot 0 = [WIDTH-1:0] written at tail, slot 1 written at tail+1
- issue_idx  out  2*IDX  indices slot 0/1 would receive (tail, tail+1 mod DEPTH)
- upd_valid  in  N_UPD  per-port update strobe
- upd_idx  in  N_UPD*IDX  per-port target index
- upd_data  in  N_UPD*WIDTH  per-port data
- commit_cnt  in  2  entries to retire this cycle (0..2)
- head_rdy  out  2  bit k = entry head+k valid and ready
- head_data  out  2*WIDTH  data at head and head+1
- head_idx  out  IDX  current head pointer
- count  out  IDX+1  occupied entries, 0..DEPTH
- free_cnt  out  IDX+1  DEPTH - count
- full, empty  out  1  count == DEPTH / count == 0
- err  out  1  one-cycle pulse on a rejected issue or commit

## Operation
- State: head, tail (IDX bits, wrap naturally mod DEPTH), count, per-entry valid and rdy bits, data array.
- Issue: accepted iff issue_cnt <= free_cnt (free_cnt of the current cycle). Accepted: write slots, set valid=1, rdy=0, tail += issue_cnt. Rejected: no state change, err=1. issue_cnt=3 is rejected.
- Commit: accepted iff commit_cnt <= number of leading set bits of head_rdy (head_rdy=01 permits 1; 10 permits 0). Accepted: clear valid/rdy of retired entries, head += commit_cnt. Rejected: no retire, err=1.
- count_next = count + accepted issue_cnt - accepted commit_cnt; simultaneous issue and commit both accepted when legal.
- Entries freed by commit are not reusable by issue in the same cycle.
- Update: port p writes data and sets rdy for entry upd_idx[p] only if that entry is valid at cycle start and not retired this cycle; otherwise ignored silently.
- Same-index updates on multiple ports: highest-numbered port wins.
- Update hitting an index being issued the same cycle is impossible (entry not valid) and is ignored; the issue write wins.
- head_rdy bit k is 0 when k >= count.

## Timing
- Reset (async assert): head=tail=0, count=0, all valid/rdy=0, empty=1, full=0, free_cnt=DEPTH, head_rdy=00, err=0, issue_idx={1,0}. Data array is not reset; head_data is don't-care while head_rdy=0.
- Reset asserted mid-operation discards all entries immediately; deassertion is synchronised externally.
- All outputs are combinational from registered state only; no input-to-output paths.
- Issue-to-visible: an entry issued in cycle n appears in count/head_data at n+1.
- Update-to-ready: update in cycle n sets head_rdy at n+1; commit earliest at n+1.
- err is registered and asserts in the cycle after the offending request.

## Configuration
- CIR_Q_FLUSH_EN defined: adds input port flush (1 bit, after commit_cnt). Flush in cycle n: at n+1 head=tail=0, count=0, all valid/rdy=0; flush overrides issue, commit and update in the same cycle; err is not raised.
- Not defined: no flush port; the queue clears only via rst.

## Test plan
- Reset, then issue_cnt=2 for DEPTH/2 cycles -> full=1, count=DEPTH, free_cnt=0; one further issue_cnt=1 -> no state change, err=1 next cycle.
- DEPTH=32: fill, update indices 0 and 1 on ports 0/1, commit_cnt=2 -> head_idx=2, count=30; continue until tail and head both wrap past 31 -> correct head_data ordering.
- head_rdy=10 with commit_cnt=1 -> err=1, head unchanged; head_rdy=01, commit_cnt=1 -> retire one.
- Ports 0 and 1 update the same valid index with 0xAAAA/0x5555 -> stored 0x5555.
- count=DEPTH, issue_cnt=1 with commit_cnt=1 in the same cycle -> commit accepted, issue rejected, count=DEPTH-1.
- With CIR_Q_FLUSH_EN: 10 entries, flush with issue_cnt=2 -> next cycle empty=1, count=0, head_idx=0, err=0.
